if_fetch_queue: RTL and testbench

- Parametrised successor to the instruction-fetch stage.
- Holds the PC and issues word-addressed requests to a 1-cycle-latency synchronous instruction memory.
- Buffers returned instructions, each tagged with its PC, in a FIFO fetch queue of configurable depth.
- Decode consumes the queue through a valid/ready handshake.
- Adds decoupled backpressure, redirect flush with in-flight kill, and a queue occupancy output.

---
 rtl/if_fetch_queue.sv | 81 ++++++++
 tb/tb_if_fetch_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: PC, 1-cycle synchronous imem request, and a FIFO of
// {instr, pc} entries drained by decode through a valid/ready handshake.
module if_fetch_queue #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int FQ_DEPTH         = 4,
  parameter logic [MEMORY_ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pc_en,
  input  logic                          redirect,
  input  logic [MEMORY_ADDR_SIZE-1:0]   redirect_addr,
  output logic                          imem_req,
  output logic [MEMORY_ADDR_SIZE-1:0]   imem_addr,
  input  logic [ARQ-1:0]                imem_rdata,
  output logic [ARQ-1:0]                instr,
  output logic [MEMORY_ADDR_SIZE-1:0]   instr_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [$clog2(FQ_DEPTH):0]     fq_count
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int PW = $clog2(FQ_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FQ_DEPTH);

  logic [MEMORY_ADDR_SIZE-1:0] pc, inflight_pc;
  logic                        inflight;
  logic [FQ_DEPTH-1:0][ARQ-1:0]              fq_instr;
  logic [FQ_DEPTH-1:0][MEMORY_ADDR_SIZE-1:0] fq_pc;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW:0]   credits_used;
  logic          push, pop;

  // An in-flight request reserves a slot, so the queue can never overflow.
  assign credits_used = {1'b0, fq_count} + {{CW{1'b0}}, inflight};
  assign imem_req     = rst & pc_en & ~redirect & (credits_used < DEPTH_W);
  assign imem_addr    = pc;

  assign instr_valid = (fq_count != '0);
  assign instr       = instr_valid ? fq_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fq_pc[rd_ptr]    : '0;

  // Redirect kills the response landing this cycle and flushes the queue.
  assign push = inflight & ~redirect;
  assign pop  = instr_valid & instr_ready & ~redirect;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fq_count    <= '0;
    end else if (redirect) begin
      pc       <= redirect_addr;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fq_count <= '0;
    end else begin
      if (imem_req) begin
        pc          <= pc + MEMORY_ADDR_SIZE'(1);
        inflight_pc <= pc;
      end
      inflight <= imem_req;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fq_count <= fq_count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset: contents are only exposed while counted valid.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      fq_instr[wr_ptr] <= imem_rdata;
      fq_pc[wr_ptr]    <= inflight_pc;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed table-driven bench for if_fetch_queue with imem_rdata = 16'hA000 | addr.
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, pc_en, redirect, instr_ready;
  logic [12:0] redirect_addr;
  logic        imem_req;
  logic [12:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic [12:0] instr_pc;
  logic        instr_valid;
  logic [2:0]  fq_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .redirect(redirect),
    .redirect_addr(redirect_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .fq_count(fq_count)
  );

  // 1-cycle-latency synchronous instruction memory
  always @(posedge clk) imem_rdata <= 16'hA000 | {3'b000, imem_addr};

  typedef struct {
    logic r, en, rd;
    logic [12:0] ra;
    logic rdy;
    logic ereq;
    logic [12:0] eaddr;
    logic evld;
    logic [12:0] epc;
    logic [2:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, en, rd, input logic [12:0] ra, input logic rdy,
                              input logic ereq, input logic [12:0] eaddr, input logic evld,
                              input logic [12:0] epc, input logic [2:0] ecnt);
    vec_t v;
    v = '{r, en, rd, ra, rdy, ereq, eaddr, evld, epc, ecnt};
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic drive(input logic r, en, rd, input logic [12:0] ra, input logic rdy);
    rst = r; pc_en = en; redirect = rd; redirect_addr = ra; instr_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ei;
    int waited;

    // rst, en, redir, raddr, rdy | req, addr, vld, head pc, count
    vecs.push_back(mk(0,1,0,13'h0000,1, 0,13'h0000,0,13'h0000,0)); // reset state
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0000,0,13'h0000,0)); // R
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0001,0,13'h0000,0));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0002,1,13'h0000,1)); // R+2 first valid
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0003,1,13'h0001,1));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0004,1,13'h0002,1));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0005,1,13'h0003,1));
    vecs.push_back(mk(0,1,1,13'h0100,0, 0,13'h0006,1,13'h0004,1)); // reset + redirect
    vecs.push_back(mk(1,1,0,13'h0000,0, 1,13'h0000,0,13'h0000,0)); // reset won
    vecs.push_back(mk(1,1,0,13'h0000,0, 1,13'h0001,0,13'h0000,0));
    vecs.push_back(mk(1,1,0,13'h0000,0, 1,13'h0002,1,13'h0000,1));
    vecs.push_back(mk(1,1,0,13'h0000,0, 1,13'h0003,1,13'h0000,2));
    vecs.push_back(mk(1,1,0,13'h0000,0, 0,13'h0004,1,13'h0000,3)); // credits exhausted
    vecs.push_back(mk(1,1,0,13'h0000,0, 0,13'h0004,1,13'h0000,4)); // full
    vecs.push_back(mk(1,1,0,13'h0000,0, 0,13'h0004,1,13'h0000,4));
    vecs.push_back(mk(1,1,0,13'h0000,1, 0,13'h0004,1,13'h0000,4)); // release
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0004,1,13'h0001,3));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0005,1,13'h0002,2));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0006,1,13'h0003,2));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0007,1,13'h0004,2));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0008,1,13'h0005,2));
    vecs.push_back(mk(1,1,0,13'h0000,0, 1,13'h0009,1,13'h0006,2));
    vecs.push_back(mk(1,1,1,13'h000D,0, 0,13'h000A,1,13'h0006,3)); // 3 queued + 1 in flight
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h000D,0,13'h0000,0));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h000E,0,13'h0000,0));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h000F,1,13'h000D,1));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0010,1,13'h000E,1));
    vecs.push_back(mk(1,1,1,13'h1FFF,1, 0,13'h0011,1,13'h000F,1)); // redirect to top
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h1FFF,0,13'h0000,0));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0000,0,13'h0000,0)); // pc wrapped
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0001,1,13'h1FFF,1));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0002,1,13'h0000,1));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0003,1,13'h0001,1));
    vecs.push_back(mk(1,0,0,13'h0000,1, 0,13'h0004,1,13'h0002,1)); // pc_en low
    vecs.push_back(mk(1,0,0,13'h0000,1, 0,13'h0004,1,13'h0003,1)); // pending delivered
    vecs.push_back(mk(1,0,0,13'h0000,1, 0,13'h0004,0,13'h0000,0));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0004,0,13'h0000,0)); // resume at held pc
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0005,0,13'h0000,0));
    vecs.push_back(mk(1,1,0,13'h0000,1, 1,13'h0006,1,13'h0004,1));

    drive(0, 1, 0, 13'h0000, 1);
    tick();
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].en, vecs[i].rd, vecs[i].ra, vecs[i].rdy);
      #1;
      ei = vecs[i].evld ? (16'hA000 | {3'b000, vecs[i].epc}) : 16'h0000;
      chk("imem_req",    i, 32'(imem_req),    32'(vecs[i].ereq));
      chk("imem_addr",   i, 32'(imem_addr),   32'(vecs[i].eaddr));
      chk("instr_valid", i, 32'(instr_valid), 32'(vecs[i].evld));
      chk("instr_pc",    i, 32'(instr_pc),    32'(vecs[i].epc));
      chk("instr",       i, 32'(instr),       32'(ei));
      chk("fq_count",    i, 32'(fq_count),    32'(vecs[i].ecnt));
      tick();
    end

    // Redirect latency and sustained 1/cycle throughput afterwards
    drive(1, 1, 1, 13'h0040, 1);
    #1;
    chk("redir_noreq", 0, 32'(imem_req), 32'd0);
    tick();
    drive(1, 1, 0, 13'h0000, 1);
    #1;
    chk("redir_req",  0, 32'(imem_req),  32'd1);
    chk("redir_addr", 0, 32'(imem_addr), 32'h40);
    chk("redir_cnt",  0, 32'(fq_count),  32'd0);
    waited = 0;
    while (!instr_valid && waited < 6) begin
      tick();
      waited++;
    end
    chk("redir_lat", 0, 32'(waited), 32'd2);
    for (int k = 0; k < 8; k++) begin
      chk("stream_vld", k, 32'(instr_valid), 32'd1);
      chk("stream_pc",  k, 32'(instr_pc),    32'h40 + 32'(k));
      chk("stream_ins", k, 32'(instr),       32'hA040 + 32'(k));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
